// File: rtl/core_pkg.sv
// Shared definitions for the memory-side blocks: read-response owner
// encoding and the word-address width.
package core_pkg;

    localparam int WORD_ADDR_W = 30;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/starve_counter.sv
// Saturating counter of consecutive denied fetch cycles. Clear wins over
// increment; at_limit_o flags that the count has reached LIMIT.
module starve_counter #(
    parameter int LIMIT = 4,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic resetb,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_limit_o
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign at_limit_o = (cnt_q == LIMIT_C);

    // Next count: clear on a fetch grant, otherwise count up until saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_limit_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared instruction/data memory read port.
// Data reads beat fetch reads unless fetch has been denied STARVE_LIMIT
// cycles in a row; data writes bypass arbitration onto the write port.
//
// Read-response owner register:
//   owner    | meaning
//   OWN_NONE | no read issued last cycle, no rvalid this cycle
//   OWN_I    | fetch read issued last cycle, i_rvalid this cycle
//   OWN_D    | data read issued last cycle, d_rvalid this cycle
module mem_arbiter
    import core_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   i_req,
    input  logic [WORD_ADDR_W-1:0] i_addr,
    output logic                   i_gnt,
    output logic                   i_rvalid,
    output logic [31:0]            i_rdata,
    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [WORD_ADDR_W-1:0] d_addr,
    input  logic [31:0]            d_wdata,
    input  logic [3:0]             d_wbyte,
    output logic                   d_gnt,
    output logic                   d_rvalid,
    output logic [31:0]            d_rdata,
    output logic                   mem_read_ready,
    output logic [WORD_ADDR_W-1:0] mem_read_address,
    output logic                   mem_write_ready,
    output logic [WORD_ADDR_W-1:0] mem_write_address,
    output logic [31:0]            mem_write_data,
    output logic [3:0]             mem_write_byte,
    input  logic [31:0]            mem_read_data
);

    owner_e owner_q;
    owner_e owner_d;
    logic   at_limit;
    logic   force_i;
    logic   d_rd_req;
    logic   d_rd_gnt;

    assign d_rd_req = d_req && !d_we;
    assign force_i  = (STARVE_LIMIT != 0) && at_limit;

    // Grants, memory port drive and next owner. Every enable is qualified
    // by resetb so nothing is issued while reset is asserted.
    always_comb begin
        i_gnt            = 1'b0;
        d_gnt            = 1'b0;
        d_rd_gnt         = 1'b0;
        mem_read_ready   = 1'b0;
        mem_read_address = i_addr;
        owner_d          = OWN_NONE;

        if (resetb) begin
            i_gnt    = i_req && (!d_rd_req || force_i);
            d_rd_gnt = d_rd_req && !(i_req && force_i);
            d_gnt    = (d_req && d_we) || d_rd_gnt;
        end

        if (d_rd_gnt) begin
            mem_read_ready   = 1'b1;
            mem_read_address = d_addr;
            owner_d          = OWN_D;
        end else if (i_gnt) begin
            mem_read_ready   = 1'b1;
            owner_d          = OWN_I;
        end
    end

    assign mem_write_ready   = resetb && d_req && d_we;
    assign mem_write_address = d_addr;
    assign mem_write_data    = d_wdata;
    assign mem_write_byte    = d_wbyte;

    // Owner register steers the one-cycle-later read response.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign i_rvalid = (owner_q == OWN_I);
    assign d_rvalid = (owner_q == OWN_D);
    assign i_rdata  = mem_read_data;
    assign d_rdata  = mem_read_data;

    starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve (
        .clk        (clk),
        .resetb     (resetb),
        .clr_i      (i_gnt),
        .inc_i      (i_req && !i_gnt),
        .at_limit_o (at_limit)
    );

endmodule
